data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Word-addressed data memory answering the MEM stage's load/store requests
//  (mem_r_en / mem_w_en, ALU address, Rm store data) with a multi-cycle
//  ready handshake. Models a wait-stated data memory. The pipeline freezes
//  all stages while ready is low.
// PARAMETERS
//  ADDR_BASE    1024  byte address mapped to word 0
//  DEPTH        64    number of 32-bit words (power of 2)
//  WAIT_STATES  2     cycles spent in ACCESS per request (0 allowed)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  mem_r_en   in   1   load request; held stable by requester until ready
//  mem_w_en   in   1   store request; held stable by requester until ready
//  address    in   32  byte address (ALU result)
//  wr_data    in   32  store data (val_Rm)
//  rd_data    out  32  load data; registered, valid in DONE, held after
//  ready      out  1   1 = no request pending or request completing this cycle
//  err        out  1   only with DMEM_RANGE_CHECK_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset: state=IDLE, rd_data=0, err=0, count=0, latches cleared.
//    Memory array is not cleared.
//  - ready = (state==IDLE && !(mem_r_en|mem_w_en)) || state==DONE.
//    Combinational, so freeze asserts in the request cycle.
//  - FSM: IDLE -> (req) ACCESS, or DONE if WAIT_STATES==0.
//    ACCESS: counter counts 0..WAIT_STATES-1, then -> DONE.
//    DONE -> IDLE unconditionally.
//  - On the IDLE->ACCESS/DONE edge: latch address, wr_data, op.
//    Requester changes or deassertion after acceptance is ignored.
//  - Latency: request cycle + WAIT_STATES + DONE = WAIT_STATES+2 cycles.
//    ready=1 only in the final (DONE) cycle.
//  - Index = ((addr_latched - ADDR_BASE) >> 2) truncated to log2(DEPTH) bits.
//    addr[1:0] is ignored, so no unaligned support.
//    Below-base and above-top addresses wrap modulo DEPTH.
//  - Write committed, and rd_data loaded for reads, on the edge entering DONE.
//  - mem_r_en & mem_w_en both high: treated as a write; rd_data unchanged.
//  - Back-to-back: a new request seen in the cycle after DONE (IDLE)
//    is accepted immediately, with no extra bubble.
//  - Reset mid-access: abort to IDLE; pending write discarded; rd_data=0.
// CONFIGURATION
//  DMEM_RANGE_CHECK_EN defined:
//    - Address outside [ADDR_BASE, ADDR_BASE+4*DEPTH): write dropped,
//      read returns rd_data=0.
//    - err=1 during the DONE cycle only; else 0.
//  Undefined:
//    - err port tied 0; out-of-range addresses wrap as above.
// TESTING
//  1 rst pulse mid-idle -> ready=1, rd_data=0x0, state IDLE next cycle.
//  2 write 0x400 <- 0xDEADBEEF (WAIT_STATES=2) -> ready 0,0,0,1;
//    then read 0x400 -> rd_data=0xDEADBEEF in DONE.
//  3 write 0x404 <- 0x12345678, then read 0x404 in the very next cycle
//    -> read accepted without bubble, returns 0x12345678.
//  4 prior 0x408=0x1; write 0x408 <- 0xFFFF0000, rst asserted in ACCESS
//    -> later read 0x408 returns 0x1.
//  5 write 0x400+4*DEPTH <- 0xA5A5A5A5:
//    no macro -> read 0x400 = 0xA5A5A5A5;
//    macro -> err=1 in DONE, read 0x400 unchanged, and an out-of-range
//    read returns 0.
//  6 r_en=w_en=1, address 0x40C, data 0x77 -> 0x40C=0x77, rd_data unchanged.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory with a wait-stated ready
// handshake for the MEM stage. A request is accepted in IDLE, spends
// WAIT_STATES cycles in ACCESS, and completes in a single DONE cycle.
// Optional feature macro: DMEM_RANGE_CHECK_EN (drop/zero out-of-range
// accesses and flag err in DONE); without it, addresses wrap modulo DEPTH.
module data_mem_responder #(
  parameter int ADDR_BASE   = 1024,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [31:0] BASE = 32'(ADDR_BASE);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          write_q, write_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          accept;
  logic          enter_done;
  logic          eff_write;
  logic          in_range;
  logic          mem_we;
  logic [31:0]   eff_addr;
  logic [31:0]   eff_wdata;
  logic [31:0]   offset;
  logic [AW-1:0] idx;

  assign req    = mem_r_en | mem_w_en;
  assign accept = (state_q == IDLE) && req;

  // With zero wait states the commit happens on the accepting edge itself,
  // so the live inputs are used instead of the not-yet-latched copies.
  assign eff_addr  = accept ? address  : addr_q;
  assign eff_wdata = accept ? wr_data  : wdata_q;
  assign eff_write = accept ? mem_w_en : write_q;

  // Low address bits are dropped; anything outside the window wraps.
  assign offset = eff_addr - BASE;
  assign idx    = AW'(offset >> 2);

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [31:0] TOP = 32'(ADDR_BASE + 4 * DEPTH);
  assign in_range = (eff_addr >= BASE) && (eff_addr < TOP);
`else
  assign in_range = 1'b1;
`endif

  assign ready = ((state_q == IDLE) && !req) || (state_q == DONE);

  // Next-state logic: accept in IDLE, count wait states, single DONE cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = address;
          wdata_d = wr_data;
          write_d = mem_w_en;
          count_d = '0;
          state_d = (WAIT_STATES == 0) ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (count_q == CW'(WAIT_STATES - 1)) begin
          count_d = '0;
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_done = (state_d == DONE);
  assign mem_we     = enter_done && eff_write && in_range;

  // Load data is captured on the edge entering DONE and held afterwards.
  always_comb begin
    rd_data_d = rd_data_q;
    if (enter_done && !eff_write) begin
      rd_data_d = in_range ? mem[idx] : '0;
    end
  end

  // Control and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= eff_wdata;
    end
  end

  assign rd_data = rd_data_q;

`ifdef DMEM_RANGE_CHECK_EN
  logic err_q, err_d;

  assign err_d = enter_done && !in_range;

  // Error flag is asserted only for the DONE cycle of a bad access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
